// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the host memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 512;

  typedef logic [$clog2(DEF_NUM_REQ)-1:0] owner_t;

  // Index width for a requester count, never narrower than one bit.
  function automatic int owner_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or above ptr, wrapping.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int OW = owner_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OW-1:0]      ptr,
  output logic               any,
  output logic [OW-1:0]      winner
);

  logic [NUM_REQ-1:0] rot;
  logic [OW-1:0]      off;
  logic [OW:0]        sum;

  // Rotate so ptr sits at bit 0, find the lowest set bit, then rotate back.
  always_comb begin
    rot = NUM_REQ'({req, req} >> ptr);
    off = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) off = OW'(j);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (OW+1)'(NUM_REQ)) sum = sum - (OW+1)'(NUM_REQ);
    winner = sum[OW-1:0];
    any    = |req;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-outstanding memory port among requesters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  input  logic                      buffer_addr_valid,
  output logic                      mem_read_request_valid,
  output logic                      mem_write_request_valid,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_data_d,
  input  logic                      mem_data_valid,
  input  logic                      mem_write_done,
  input  logic [DATA_W-1:0]         mem_data_q,
  output logic                      busy
);

  localparam int OW = owner_width(NUM_REQ);

  state_t        state;
  logic [OW-1:0] owner;
  logic [OW-1:0] rr_ptr;
  logic [OW-1:0] winner;
  logic [OW-1:0] next_ptr;
  logic          op_write;
  logic          any;
  logic          grant;
  logic          done;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .any    (any),
    .winner (winner)
  );

  assign grant    = buffer_addr_valid && any;
  assign next_ptr = (winner == OW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  assign done     = op_write ? mem_write_done : mem_data_valid;

  // mem_address / mem_data_d double as the latched request registers, so they
  // stay stable through WAIT without a separate copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                   <= IDLE;
      owner                   <= '0;
      rr_ptr                  <= '0;
      op_write                <= 1'b0;
      req_ack                 <= '0;
      resp_valid              <= '0;
      resp_data               <= '0;
      mem_read_request_valid  <= 1'b0;
      mem_write_request_valid <= 1'b0;
      mem_address             <= '0;
      mem_data_d              <= '0;
      busy                    <= 1'b0;
    end else begin
      req_ack                 <= '0;
      resp_valid              <= '0;
      mem_read_request_valid  <= 1'b0;
      mem_write_request_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            state                   <= ISSUE;
            busy                    <= 1'b1;
            owner                   <= winner;
            rr_ptr                  <= next_ptr;
            op_write                <= req_write[winner];
            mem_address             <= req_address[winner*ADDR_W +: ADDR_W];
            mem_data_d              <= req_data[winner*DATA_W +: DATA_W];
            req_ack                 <= NUM_REQ'(1) << winner;
            mem_write_request_valid <= req_write[winner];
            mem_read_request_valid  <= !req_write[winner];
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          // Only the completion matching the latched direction ends the wait.
          if (done) begin
            state             <= IDLE;
            busy              <= 1'b0;
            resp_valid[owner] <= 1'b1;
            if (!op_write) resp_data <= mem_data_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions, decoupled monitor.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 512;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_write = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_address = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        req_ack;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_data;
  logic                      buffer_addr_valid = 1'b1;
  logic                      mem_read_request_valid;
  logic                      mem_write_request_valid;
  logic [ADDR_W-1:0]         mem_address;
  logic [DATA_W-1:0]         mem_data_d;
  logic                      mem_data_valid = 1'b0;
  logic                      mem_write_done = 1'b0;
  logic [DATA_W-1:0]         mem_data_q = '0;
  logic                      busy;

  mem_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .req_valid               (req_valid),
    .req_write               (req_write),
    .req_address             (req_address),
    .req_data                (req_data),
    .req_ack                 (req_ack),
    .resp_valid              (resp_valid),
    .resp_data               (resp_data),
    .buffer_addr_valid       (buffer_addr_valid),
    .mem_read_request_valid  (mem_read_request_valid),
    .mem_write_request_valid (mem_write_request_valid),
    .mem_address             (mem_address),
    .mem_data_d              (mem_data_d),
    .mem_data_valid          (mem_data_valid),
    .mem_write_done          (mem_write_done),
    .mem_data_q              (mem_data_q),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                idx;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ack_exp_t;

  typedef struct {
    int                idx;
    logic [DATA_W-1:0] data;
  } resp_exp_t;

  ack_exp_t          ack_q[$];
  resp_exp_t         resp_q[$];
  ack_exp_t          mon_a;
  resp_exp_t         mon_r;
  int                checks = 0;
  int                errors = 0;
  logic [DATA_W-1:0] last_read = '0;

  task automatic check_output(input string name, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every grant or response the DUT presents is matched against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_ack != '0 || mem_read_request_valid || mem_write_request_valid) begin
        if (ack_q.size() == 0) begin
          check_output("unexpected_ack",
                       {req_ack, mem_read_request_valid, mem_write_request_valid}, '0);
        end else begin
          mon_a = ack_q.pop_front();
          check_output("ack_owner", req_ack, 1 << mon_a.idx);
          check_output("write_strobe", mem_write_request_valid, mon_a.wr);
          check_output("read_strobe", mem_read_request_valid, !mon_a.wr);
          check_output("mem_address", mem_address, mon_a.addr);
          if (mon_a.wr) check_output("mem_data_d", mem_data_d, mon_a.data);
          check_output("busy_issue", busy, 1);
        end
      end
      if (resp_valid != '0) begin
        if (resp_q.size() == 0) begin
          check_output("unexpected_resp", resp_valid, '0);
        end else begin
          mon_r = resp_q.pop_front();
          check_output("resp_owner", resp_valid, 1 << mon_r.idx);
          check_output("resp_data", resp_data, mon_r.data);
          check_output("busy_resp", busy, 0);
        end
      end
    end
  end

  task automatic apply_stimulus(input int idx, input bit wr, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] data);
    req_write[idx]                    = wr;
    req_address[idx*ADDR_W +: ADDR_W] = addr;
    req_data[idx*DATA_W +: DATA_W]    = data;
    req_valid[idx]                    = 1'b1;
  endtask

  task automatic expect_ack(input int idx, input bit wr, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] data);
    ack_exp_t e;
    e.idx  = idx;
    e.wr   = wr;
    e.addr = addr;
    e.data = data;
    ack_q.push_back(e);
  endtask

  task automatic wait_ack(output int idx, output int cyc);
    idx = -1;
    cyc = 0;
    while (idx < 0 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NUM_REQ; i++) if (req_ack[i]) idx = i;
    end
    if (idx < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_timeout: got no req_ack within %0d cycles, expected one", cyc);
    end
  endtask

  // Called at a negedge: pulse the completion for one cycle, response due next cycle.
  task automatic complete(input int idx, input bit wr, input logic [DATA_W-1:0] rdata);
    resp_exp_t e;
    e.idx = idx;
    if (wr) begin
      mem_write_done = 1'b1;
      mem_data_q     = {16{32'hBAD0_0BAD}};
      e.data         = last_read;
    end else begin
      mem_data_valid = 1'b1;
      mem_data_q     = rdata;
      e.data         = rdata;
      last_read      = rdata;
    end
    resp_q.push_back(e);
    @(negedge clk);
    mem_write_done = 1'b0;
    mem_data_valid = 1'b0;
    #1;
    check_output("resp_missing", resp_q.size(), 0);
    resp_q.delete();
  endtask

  task automatic txn(input int idx, input bit wr, input logic [ADDR_W-1:0] addr,
                     input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdata,
                     input int lat);
    int g, c;
    expect_ack(idx, wr, addr, wdata);
    apply_stimulus(idx, wr, addr, wdata);
    wait_ack(g, c);
    check_output("ack_latency", c, 1);
    if (g >= 0) req_valid[g] = 1'b0;
    repeat (lat) @(negedge clk);
    complete(idx, wr, rdata);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_req_ack"}, req_ack, '0);
    check_output({tag, "_resp_valid"}, resp_valid, '0);
    check_output({tag, "_resp_data"}, resp_data, '0);
    check_output({tag, "_rd_strobe"}, mem_read_request_valid, 0);
    check_output({tag, "_wr_strobe"}, mem_write_request_valid, 0);
    check_output({tag, "_mem_address"}, mem_address, '0);
    check_output({tag, "_mem_data_d"}, mem_data_d, '0);
    check_output({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    ack_q.delete();
    resp_q.delete();
    req_valid = '0;
    last_read = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g, c, cnt;

    // Reset state and a single read with 5-cycle memory latency.
    do_reset();
    txn(0, 1'b0, 32'h100, '0, {64{8'hA5}}, 5);

    // Fairness: all four held, each re-requesting after its response.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) apply_stimulus(i, 1'b0, 32'h1000 + 32'(i) * 32'h40, '0);
    for (int k = 0; k < 8; k++)
      expect_ack(k % 4, 1'b0, 32'h1000 + 32'(k % 4) * 32'h40, '0);
    for (int k = 0; k < 8; k++) begin
      wait_ack(g, c);
      if (g >= 0) req_valid[g] = 1'b0;
      repeat (2) @(negedge clk);
      complete(k % 4, 1'b0, {16{32'h1111_0000 + 32'(k)}});
      if (k < 4) apply_stimulus(k % 4, 1'b0, 32'h1000 + 32'(k % 4) * 32'h40, '0);
    end

    // Pointer wrap: req2 alone moves the pointer to 3, then req1 and req3 compete.
    do_reset();
    txn(2, 1'b0, 32'h220, '0, {32{16'hC3C3}}, 2);
    expect_ack(3, 1'b0, 32'h330, '0);
    expect_ack(1, 1'b1, 32'h110, {32{16'h7E81}});
    apply_stimulus(1, 1'b1, 32'h110, {32{16'h7E81}});
    apply_stimulus(3, 1'b0, 32'h330, '0);
    wait_ack(g, c);
    if (g >= 0) req_valid[g] = 1'b0;
    repeat (3) @(negedge clk);
    complete(3, 1'b0, {64{8'h3C}});
    wait_ack(g, c);
    check_output("wrap_second_latency", c, 1);
    if (g >= 0) req_valid[g] = 1'b0;
    repeat (2) @(negedge clk);
    complete(1, 1'b1, '0);

    // Gating: nothing is granted while the memory port is unconfigured.
    buffer_addr_valid = 1'b0;
    apply_stimulus(2, 1'b0, 32'h2F0, '0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (req_ack != '0 || mem_read_request_valid || mem_write_request_valid) cnt++;
    end
    check_output("gated_activity", cnt, 0);
    check_output("gated_busy", busy, 0);
    expect_ack(2, 1'b0, 32'h2F0, '0);
    buffer_addr_valid = 1'b1;
    wait_ack(g, c);
    check_output("gate_release_latency", c, 1);
    if (g >= 0) req_valid[g] = 1'b0;
    repeat (2) @(negedge clk);
    complete(2, 1'b0, {8{64'h0123_4567_89AB_CDEF}});

    // Write with a stray read completion during WAIT.
    expect_ack(1, 1'b1, 32'h200, {64{8'h5A}});
    apply_stimulus(1, 1'b1, 32'h200, {64{8'h5A}});
    wait_ack(g, c);
    if (g >= 0) req_valid[g] = 1'b0;
    repeat (2) @(negedge clk);
    mem_data_valid = 1'b1;
    mem_data_q     = {16{32'hDEAD_BEEF}};
    @(negedge clk);
    mem_data_valid = 1'b0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid != '0) cnt++;
    end
    check_output("stray_resp_count", cnt, 0);
    check_output("stray_busy", busy, 1);
    complete(1, 1'b1, '0);

    // Reset while a read is outstanding in WAIT.
    expect_ack(0, 1'b0, 32'h400, '0);
    apply_stimulus(0, 1'b0, 32'h400, '0);
    wait_ack(g, c);
    if (g >= 0) req_valid[g] = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    ack_q.delete();
    resp_q.delete();
    last_read = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("post_reset_busy", busy, 0);
    mem_data_valid = 1'b1;
    mem_data_q     = {64{8'hEE}};
    @(negedge clk);
    mem_data_valid = 1'b0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid != '0) cnt++;
    end
    check_output("late_completion_resp", cnt, 0);

    // Pointer back at 0: req0 beats req1.
    expect_ack(0, 1'b0, 32'h500, '0);
    expect_ack(1, 1'b1, 32'h510, {64{8'h99}});
    apply_stimulus(0, 1'b0, 32'h500, '0);
    apply_stimulus(1, 1'b1, 32'h510, {64{8'h99}});
    wait_ack(g, c);
    if (g >= 0) req_valid[g] = 1'b0;
    repeat (2) @(negedge clk);
    complete(0, 1'b0, {64{8'h42}});
    wait_ack(g, c);
    if (g >= 0) req_valid[g] = 1'b0;
    repeat (2) @(negedge clk);
    complete(1, 1'b1, '0);

    repeat (3) @(negedge clk);
    check_output("ack_queue_drained", ack_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares the single-outstanding-transaction host memory port among `NUM_REQ` requesters. The host memory port has one address bus, one read/write request strobe pair and one completion pair. The arbiter sits between that port and the compute units, for example the control unit and later pipeline stages. It grants one requester at a time, drives the memory request, waits for completion and routes the read data or write acknowledgement back to the owner.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `ADDR_W`, 32, address width
- `DATA_W`, 512, cache-line width

Ports (reset is asynchronous, active-low):
- `clk` in 1: the single clock
- `rst_n` in 1: asynchronous active-low reset
- `req_valid` in NUM_REQ: request pending, held high until `req_ack`
- `req_write` in NUM_REQ: 1 = write, 0 = read
- `req_address` in NUM_REQ*ADDR_W: per-requester address, slice i = bits [i*ADDR_W +: ADDR_W]
- `req_data` in NUM_REQ*DATA_W: per-requester write data
- `req_ack` out NUM_REQ: one-cycle pulse, request accepted
- `resp_valid` out NUM_REQ: one-cycle pulse, transaction complete for that requester
- `resp_data` out DATA_W: read data, valid with `resp_valid`; shared by all requesters
- `buffer_addr_valid` in 1: memory port configured; new grants are allowed only while high
- `mem_read_request_valid` out 1: read strobe to memory
- `mem_write_request_valid` out 1: write strobe to memory
- `mem_address` out ADDR_W: memory address
- `mem_data_d` out DATA_W: memory write data
- `mem_data_valid` in 1: read completion
- `mem_write_done` in 1: write completion
- `mem_data_q` in DATA_W: read data from memory
- `busy` out 1: a transaction is in flight (state ≠ IDLE)

## Operation
- State machine:
  - IDLE → ISSUE when `buffer_addr_valid` is high and `req_valid` is nonzero.
  - ISSUE → WAIT unconditionally.
  - WAIT → IDLE on the matching completion.
- Winner selection:
  - The winner is the first set `req_valid` bit searching upward from `rr_ptr`, wrapping modulo NUM_REQ.
  - On the grant edge, these are latched: `owner` ← winner, `op_write` ← `req_write[winner]`, the address register ← `req_address` slice and the data register ← `req_data` slice.
  - `rr_ptr` ← (winner+1) mod NUM_REQ on the same edge.
- ISSUE cycle:
  - `req_ack[owner]` = 1.
  - Exactly one of `mem_read_request_valid` / `mem_write_request_valid` = 1, chosen by `op_write`.
- WAIT:
  - The strobes are 0. `mem_address` and `mem_data_d` hold the latched values through WAIT.
  - Matching completion is `mem_data_valid` for a read and `mem_write_done` for a write.
  - On matching completion: `resp_valid[owner]` ← 1 for one cycle; for a read, `resp_data` ← `mem_data_q`; state → IDLE.
  - The non-matching completion is ignored in WAIT.
- Completions arriving in IDLE or ISSUE are ignored. No error is flagged.
- `buffer_addr_valid` falling while in ISSUE/WAIT has no effect on the in-flight transaction. It only blocks the next grant.
- `resp_data` holds its last read value between responses. After a write response, `resp_data` is unchanged.
- Reset (asserted at any time, including mid-transaction):
  - All outputs go to 0: `req_ack`, `resp_valid`, `resp_data`, both strobes, `mem_address`, `mem_data_d`, `busy`.
  - State ← IDLE, `rr_ptr` ← 0.
  - The in-flight transaction is dropped; the requester reissues.

## Timing
- Request seen in IDLE at edge T (with `buffer_addr_valid`=1) → ISSUE during cycle T+1. In that cycle, `req_ack` and the memory strobe are high together. WAIT starts at T+2.
- Completion seen at edge W → `resp_valid` high during cycle W+1. The FSM is IDLE in W+1, so the next grant can land at ISSUE in W+2.
- Minimum spacing between back-to-back transactions is 3 cycles plus memory latency.
- Requesters must hold `req_*` stable while `req_valid` is high, until they see `req_ack`. They may drop `req_valid` in the cycle after `req_ack`.
  - Because the fields are latched at grant, changes after T are harmless.
  - A requester that deasserts `req_valid` without receiving `req_ack` withdraws its request.
- A requester must not issue a new request before receiving its `resp_valid`. The arbiter does not check this.

## Structure
- Package `mem_arb_pkg`:
  - `state_t` enum {IDLE, ISSUE, WAIT}
  - default `ADDR_W`/`DATA_W` constants
  - `owner_t` typedef, width `$clog2(NUM_REQ)`
- Sub-module `rr_pick`: combinational rotating priority encoder. Inputs are `req` [NUM_REQ] and `ptr`; outputs are `any` and `winner`. Implement with a double-width mask or a rotate-and-encode.

## Test plan
- Single read: req0 reads address 0x100, memory returns `mem_data_valid` 5 cycles after the strobe with data 0xA5…A5 → the read strobe is high for exactly 1 cycle with `mem_address`=0x100, `resp_valid[0]` is high 1 cycle after completion, and `resp_data`=0xA5…A5.
- Fairness: req0..req3 all held high continuously, each re-requesting after its response → grant order is 0,1,2,3,0,1,2,3 and no requester gets two grants before the others each get one.
- Pointer wrap: `rr_ptr`=3 with only req1 and req3 pending → req3 wins and `rr_ptr` becomes 0; the next grant goes to req1.
- Gating: `buffer_addr_valid`=0 with req2 pending for 10 cycles → no `req_ack` and no strobe. After `buffer_addr_valid` rises, ISSUE follows on the next cycle.
- Completion handling: a write by req1, with a stray `mem_data_valid` during WAIT, then `mem_write_done` → the stray pulse is ignored, and `resp_valid[1]` fires only after `mem_write_done` with `resp_data` unchanged.
- Reset in WAIT: assert `rst_n`=0 while req0's read is outstanding → all outputs are 0 asynchronously, and after release `busy`=0 and `rr_ptr`=0. A late `mem_data_valid` after release produces no `resp_valid`.
